alu_issue_stage: RTL and testbench

//  Decode/operand-issue stage directly upstream of the alu. Accepts 32-bit instruction words over a

---
 rtl/alu_pkg.sv | 65 ++++++
 rtl/alu_issue_stage_if.sv | 36 +++
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_issue_stage.sv | 114 +++++++++++
 tb/tb_alu_issue_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants, opcode map and decode helpers for the alu issue stage.
package alu_pkg;

    localparam int NREG = 16;
    localparam int DW   = 32;
    localparam int AW   = $clog2(NREG);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_MOVI = 4'b0110;
    localparam logic [3:0] OP_MOV  = 4'b0111;
    localparam logic [3:0] OP_CMP  = 4'b1011;
    localparam logic [3:0] OP_LDR  = 4'b1101;
    localparam logic [3:0] OP_STR  = 4'b1110;

    // Instruction field LSB positions
    localparam int COND_LSB = 28;
    localparam int OPC_LSB  = 24;
    localparam int S_BIT    = 23;
    localparam int SRC_LSB  = 20;
    localparam int RD_LSB   = 16;
    localparam int RN_LSB   = 12;
    localparam int RM_LSB   = 8;
    localparam int SRB_LSB  = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [DW-1:0] in1;
        logic [DW-1:0] in2;
        logic [3:0]    opcode;
        logic [3:0]    cond;
        logic          s;
        logic [2:0]    sr_cont;
        logic [4:0]    sr_bit;
        logic [15:0]   immediate;
        logic [AW-1:0] rd;
        logic          illegal;
    } bundle_t;

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR,
                          OP_MOVI, OP_MOV, OP_CMP, OP_LDR, OP_STR};
    endfunction

    function automatic logic is_writer(input logic [3:0] op);
        return is_legal(op) && !(op inside {OP_CMP, OP_STR});
    endfunction

    function automatic logic uses_rn(input logic [3:0] op);
        return is_legal(op) && (op != OP_MOVI);
    endfunction

    function automatic logic uses_rm(input logic [3:0] op);
        return is_legal(op) && !(op inside {OP_MOVI, OP_MOV, OP_LDR});
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction, operand-bundle and writeback signals between the issue stage and its neighbours.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic [31:0]   Instr;
    logic          Instr_Valid;
    logic          Instr_Ready;
    logic [DW-1:0] In1;
    logic [DW-1:0] In2;
    logic [3:0]    Opcode;
    logic [3:0]    Cond;
    logic          S;
    logic [2:0]    SR_Cont;
    logic [4:0]    SR_Bit;
    logic [15:0]   Immediate;
    logic [AW-1:0] Rd;
    logic          Illegal;
    logic          Out_Valid;
    logic          Out_Ready;
    logic          Wb_En;
    logic [AW-1:0] Wb_Addr;
    logic [DW-1:0] Wb_Data;

    modport master (
        output Instr, Instr_Valid, Out_Ready, Wb_En, Wb_Addr, Wb_Data,
        input  Instr_Ready, In1, In2, Opcode, Cond, S, SR_Cont, SR_Bit,
               Immediate, Rd, Illegal, Out_Valid
    );

    modport slave (
        input  Instr, Instr_Valid, Out_Ready, Wb_En, Wb_Addr, Wb_Data,
        output Instr_Ready, In1, In2, Opcode, Cond, S, SR_Cont, SR_Bit,
               Immediate, Rd, Illegal, Out_Valid
    );

endinterface

// File: rtl/alu_regfile.sv
// NREG x DW register file: two asynchronous read ports, one write port, cleared on reset.
module alu_regfile
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);

    logic [DW-1:0] mem_q [NREG];
    logic [DW-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[wa] = wd;
    end

    // NOTE: the array is flop-based and must read as zero after reset, so every entry is
    // cleared here; a RAM macro could not offer this and would need an init sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign ra_data = mem_q[ra_addr];
    assign rb_data = mem_q[rb_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/operand-issue stage: scoreboarded register reads into a one-deep output register.
// Optional macro BYPASS_EN forwards same-cycle writeback data and relieves the matching hazard.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst_n,
    alu_issue_stage_if.slave bus
);

    logic [3:0]    op;
    logic [AW-1:0] rn, rm, rd;
    logic          use_rn, use_rm;
    logic [DW-1:0] rf_rn, rf_rm;
    logic [DW-1:0] rn_val, rm_val;
    logic          rn_busy, rm_busy;
    logic          hazard, ready, issue;

    state_e         state_q, state_d;
    bundle_t        out_q, out_d;
    logic [NREG-1:0] pending_q, pending_d;

    assign op     = bus.Instr[OPC_LSB +: 4];
    assign rn     = bus.Instr[RN_LSB +: AW];
    assign rm     = bus.Instr[RM_LSB +: AW];
    assign rd     = bus.Instr[RD_LSB +: AW];
    assign use_rn = uses_rn(op);
    assign use_rm = uses_rm(op);

    alu_regfile u_regfile (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .ra_addr (rn),
        .rb_addr (rm),
        .ra_data (rf_rn),
        .rb_data (rf_rm),
        .we      (bus.Wb_En),
        .wa      (bus.Wb_Addr),
        .wd      (bus.Wb_Data)
    );

`ifdef BYPASS_EN
    logic wb_hit_rn, wb_hit_rm;
    assign wb_hit_rn = bus.Wb_En && (bus.Wb_Addr == rn);
    assign wb_hit_rm = bus.Wb_En && (bus.Wb_Addr == rm);
    assign rn_busy   = pending_q[rn] && !wb_hit_rn;
    assign rm_busy   = pending_q[rm] && !wb_hit_rm;
    assign rn_val    = wb_hit_rn ? bus.Wb_Data : rf_rn;
    assign rm_val    = wb_hit_rm ? bus.Wb_Data : rf_rm;
`else
    assign rn_busy = pending_q[rn];
    assign rm_busy = pending_q[rm];
    assign rn_val  = rf_rn;
    assign rm_val  = rf_rm;
`endif

    assign hazard = bus.Instr_Valid && ((use_rn && rn_busy) || (use_rm && rm_busy));
    assign ready  = ((state_q == ST_EMPTY) || bus.Out_Ready) && !hazard;
    assign issue  = bus.Instr_Valid && ready;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned
    // (no latch), and blocking '=' lets the later writeback/issue lines override it.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        pending_d = pending_q;

        if (bus.Wb_En) pending_d[bus.Wb_Addr] = 1'b0;

        if (issue) begin
            state_d         = ST_FULL;
            out_d.in1       = use_rn ? rn_val : '0;
            out_d.in2       = use_rm ? rm_val : '0;
            out_d.opcode    = op;
            out_d.cond      = bus.Instr[COND_LSB +: 4];
            out_d.s         = bus.Instr[S_BIT];
            out_d.sr_cont   = bus.Instr[SRC_LSB +: 3];
            out_d.sr_bit    = bus.Instr[SRB_LSB +: 5];
            out_d.immediate = bus.Instr[15:0];
            out_d.rd        = rd;
            out_d.illegal   = !is_legal(op);
            // Set after the writeback clear so a same-cycle issue to that register wins
            if (is_writer(op)) pending_d[rd] = 1'b1;
        end else if (bus.Out_Ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_EMPTY;
            out_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            pending_q <= pending_d;
        end
    end

    assign bus.Instr_Ready = ready;
    assign bus.Out_Valid   = (state_q == ST_FULL);
    assign bus.In1         = out_q.in1;
    assign bus.In2         = out_q.in2;
    assign bus.Opcode      = out_q.opcode;
    assign bus.Cond        = out_q.cond;
    assign bus.S           = out_q.s;
    assign bus.SR_Cont     = out_q.sr_cont;
    assign bus.SR_Bit      = out_q.sr_bit;
    assign bus.Immediate   = out_q.immediate;
    assign bus.Rd          = out_q.rd;
    assign bus.Illegal     = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: decode, scoreboard stalls, hold and reset.
module tb_alu_issue_stage;
    import alu_pkg::*;

`ifdef BYPASS_EN
    localparam int BYPASS = 1;
`else
    localparam int BYPASS = 0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rn, input logic [3:0] rm,
                                       input logic [7:0] lo);
        return {4'h0, op, 1'b0, 3'b000, rd, rn, rm, lo};
    endfunction

    task automatic wb(input logic [3:0] addr, input logic [31:0] data);
        bus.Wb_En   = 1'b1;
        bus.Wb_Addr = addr;
        bus.Wb_Data = data;
        step();
        bus.Wb_En   = 1'b0;
    endtask

    // Presents one instruction, expects it to be accepted this cycle, then advances one edge.
    task automatic issue(input string tag, input logic [31:0] instr);
        bus.Instr       = instr;
        bus.Instr_Valid = 1'b1;
        #1;
        check(tag, 32'(bus.Instr_Ready), 32'd1);
        step();
        bus.Instr_Valid = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.Instr       = '0;
        bus.Instr_Valid = 1'b0;
        bus.Out_Ready   = 1'b1;
        bus.Wb_En       = 1'b0;
        bus.Wb_Addr     = '0;
        bus.Wb_Data     = '0;

        #2;
        check("rst_out_valid", 32'(bus.Out_Valid), 32'd0);
        check("rst_in1",       bus.In1,            32'd0);
        check("rst_opcode",    32'(bus.Opcode),    32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1: preload and plain ADD
        wb(4'd1, 32'd15);
        wb(4'd2, 32'd20);
        issue("add_ready", mk(OP_ADD, 4'd3, 4'd1, 4'd2, 8'h00));
        check("add_valid",  32'(bus.Out_Valid), 32'd1);
        check("add_in1",    bus.In1,            32'd15);
        check("add_in2",    bus.In2,            32'd20);
        check("add_opcode", 32'(bus.Opcode),    32'(OP_ADD));
        check("add_rd",     32'(bus.Rd),        32'd3);

        // 2: MOVI has no sources but marks R4 pending
        issue("movi_ready", mk(OP_MOVI, 4'd4, 4'd0, 4'd0, 8'd60));
        check("movi_valid", 32'(bus.Out_Valid), 32'd1);
        check("movi_imm",   32'(bus.Immediate), 32'd60);
        check("movi_in1",   bus.In1,            32'd0);
        check("movi_in2",   bus.In2,            32'd0);
        bus.Instr       = mk(OP_MOV, 4'd7, 4'd4, 4'd0, 8'h00);
        bus.Instr_Valid = 1'b1;
        #1;
        check("mov_r4_stall", 32'(bus.Instr_Ready), 32'd0);
        bus.Instr_Valid = 1'b0;
        wb(4'd4, 32'd60);

        // 3: SUB reading R3 waits for its writeback
        bus.Instr       = mk(OP_SUB, 4'd8, 4'd3, 4'd1, 8'h00);
        bus.Instr_Valid = 1'b1;
        #1;
        check("sub_stall0", 32'(bus.Instr_Ready), 32'd0);
        step();
        check("sub_stall1", 32'(bus.Instr_Ready), 32'd0);
        check("idle_drain", 32'(bus.Out_Valid),   32'd0);
        bus.Wb_En   = 1'b1;
        bus.Wb_Addr = 4'd3;
        bus.Wb_Data = 32'd35;
        #1;
        lat = 0;
        while (!bus.Instr_Ready && lat < 4) begin
            step();
            bus.Wb_En = 1'b0;
            lat++;
            #1;
        end
        check("sub_wait_cycles", 32'(lat), 32'(1 - BYPASS));
        step();
        bus.Wb_En       = 1'b0;
        bus.Instr_Valid = 1'b0;
        check("sub_valid",  32'(bus.Out_Valid), 32'd1);
        check("sub_in1",    bus.In1,            32'd35);
        check("sub_in2",    bus.In2,            32'd15);
        check("sub_opcode", 32'(bus.Opcode),    32'(OP_SUB));

        // 4: downstream back-pressure holds the bundle, then back-to-back issue
        bus.Out_Ready   = 1'b0;
        bus.Instr       = mk(OP_OR, 4'd9, 4'd1, 4'd2, 8'h00);
        bus.Instr_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_ready", 32'(bus.Instr_Ready), 32'd0);
            step();
            check("hold_valid", 32'(bus.Out_Valid), 32'd1);
            check("hold_in1",   bus.In1,            32'd35);
            check("hold_op",    32'(bus.Opcode),    32'(OP_SUB));
        end
        bus.Out_Ready = 1'b1;
        issue("release_ready", mk(OP_OR, 4'd9, 4'd1, 4'd2, 8'h00));
        check("or_valid",  32'(bus.Out_Valid), 32'd1);
        check("or_opcode", 32'(bus.Opcode),    32'(OP_OR));
        check("or_in1",    bus.In1,            32'd15);
        check("or_in2",    bus.In2,            32'd20);

        // 5: CMP/STR/illegal leave the scoreboard untouched
        issue("cmp_ready", mk(OP_CMP, 4'd5, 4'd1, 4'd2, 8'h00));
        issue("str_ready", mk(OP_STR, 4'd6, 4'd1, 4'd2, 8'h00));
        issue("ill_ready", {4'hA, 4'hF, 1'b1, 3'd5, 4'd10, 4'd0, 4'd0, 8'hA8});
        check("ill_flag",   32'(bus.Illegal),   32'd1);
        check("ill_cond",   32'(bus.Cond),      32'hA);
        check("ill_s",      32'(bus.S),         32'd1);
        check("ill_srcont", 32'(bus.SR_Cont),   32'd5);
        check("ill_srbit",  32'(bus.SR_Bit),    32'd21);
        check("ill_imm",    32'(bus.Immediate), 32'h00A8);
        check("ill_rd",     32'(bus.Rd),        32'd10);
        check("ill_in1",    bus.In1,            32'd0);
        issue("mov_r5_ready", mk(OP_MOV, 4'd11, 4'd5, 4'd0, 8'h00));
        check("mov_r5_op",  32'(bus.Opcode),  32'(OP_MOV));
        check("mov_r5_ill", 32'(bus.Illegal), 32'd0);
        check("mov_r5_in2", bus.In2,          32'd0);
        issue("add_r6_r10_ready", mk(OP_ADD, 4'd13, 4'd6, 4'd10, 8'h00));
        check("add_r6_op", 32'(bus.Opcode), 32'(OP_ADD));

        // 6: reset while FULL with R3 pending
        issue("add_r3_ready", mk(OP_ADD, 4'd3, 4'd1, 4'd2, 8'h00));
        bus.Out_Ready = 1'b0;
        step();
        check("pre_rst_valid", 32'(bus.Out_Valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.Out_Valid), 32'd0);
        check("mid_rst_in1",   bus.In1,            32'd0);
        check("mid_rst_op",    32'(bus.Opcode),    32'd0);
        check("mid_rst_rd",    32'(bus.Rd),        32'd0);
        step();
        rst_n         = 1'b1;
        bus.Out_Ready = 1'b1;
        step();
        issue("post_rst_r3_ready", mk(OP_MOV, 4'd4, 4'd3, 4'd0, 8'h00));
        check("post_rst_valid", 32'(bus.Out_Valid), 32'd1);
        check("post_rst_r3",    bus.In1,            32'd0);
        issue("post_rst_r1r2_ready", mk(OP_ADD, 4'd7, 4'd1, 4'd2, 8'h00));
        check("post_rst_r1", bus.In1, 32'd0);
        check("post_rst_r2", bus.In2, 32'd0);
        step();
        check("drain_valid", 32'(bus.Out_Valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
